// File: rtl/round_sat_pipe.sv
// Multi-channel round-then-clip stage: narrows WIDTH_IN samples to WIDTH_OUT under a per-beat rounding mode.
// Latency 2 cycles, 1 beat/cycle; a single global stall (in_ready = !out_valid | out_ready) freezes both stages.
module round_sat_pipe #(
  parameter int WIDTH_IN  = 32,
  parameter int WIDTH_OUT = 16,
  parameter int SHIFT     = 12,
  parameter int NUM_CH    = 4,
  parameter int IS_SIGNED = 1,
  parameter int CNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_CH*WIDTH_IN-1:0]    in_data,
  input  logic [1:0]                    in_mode,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_CH*WIDTH_OUT-1:0]   out_data,
  output logic [NUM_CH-1:0]             out_sat,
  output logic [CNT_W-1:0]              sat_count,
  input  logic                          clr_count
);

  // Quotient plus one guard bit so Q+inc can never wrap.
  localparam int QW = WIDTH_IN - SHIFT + 1;
  localparam logic [SHIFT-1:0] HALF = SHIFT'(1) << (SHIFT - 1);
  localparam logic [WIDTH_OUT-1:0] MAX_OUT =
    (IS_SIGNED != 0) ? {1'b0, {(WIDTH_OUT-1){1'b1}}} : {WIDTH_OUT{1'b1}};
  localparam logic [WIDTH_OUT-1:0] MIN_OUT =
    (IS_SIGNED != 0) ? {1'b1, {(WIDTH_OUT-1){1'b0}}} : {WIDTH_OUT{1'b0}};

  logic                          advance;
  logic                          s1_vld;
  logic [NUM_CH*QW-1:0]          v_nxt;
  logic [NUM_CH*QW-1:0]          s1_v;
  logic [NUM_CH-1:0]             neg_nxt;
  logic [NUM_CH-1:0]             s1_neg;
  logic [NUM_CH*WIDTH_OUT-1:0]   clip_dat;
  logic [NUM_CH-1:0]             clip_flag;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [WIDTH_IN-1:0]     din;
    logic [SHIFT-1:0]        rem;
    logic                    neg;
    logic [QW-1:0]           q;
    logic                    inc;
    logic [QW-1:0]           v;
    logic [QW-WIDTH_OUT:0]   top;
    logic                    in_rng;

    assign din = in_data[c*WIDTH_IN +: WIDTH_IN];
    assign rem = din[SHIFT-1:0];
    assign neg = (IS_SIGNED != 0) && din[WIDTH_IN-1];
    assign q   = {neg, din[WIDTH_IN-1:SHIFT]};

    always_comb begin
      inc = 1'b0;
      case (in_mode)
        2'd0:    inc = (rem > HALF) || ((rem == HALF) && q[0]);
        2'd1:    inc = (rem > HALF) || ((rem == HALF) && !neg);
        2'd2:    inc = 1'b0;
        default: inc = (rem >= HALF);
      endcase
    end

    assign v_nxt[c*QW +: QW] = q + QW'(inc);
    assign neg_nxt[c]        = neg;

    // In range when every bit above the output field is a copy of the sign (or zero if unsigned).
    // Out of range implies V has the same sign as the input, so the registered sign picks the rail.
    assign v   = s1_v[c*QW +: QW];
    assign top = v[QW-1:WIDTH_OUT-1];
    assign in_rng = (IS_SIGNED != 0) ? ((top == '0) || (top == '1))
                                     : (top[QW-WIDTH_OUT:1] == '0);

    assign clip_dat[c*WIDTH_OUT +: WIDTH_OUT] =
      in_rng ? v[WIDTH_OUT-1:0] : (s1_neg[c] ? MIN_OUT : MAX_OUT);
    assign clip_flag[c] = !in_rng;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld    <= 1'b0;
      s1_v      <= '0;
      s1_neg    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= '0;
    end else if (advance) begin
      s1_vld    <= in_valid;
      out_valid <= s1_vld;
      if (in_valid) begin
        s1_v   <= v_nxt;
        s1_neg <= neg_nxt;
      end
      if (s1_vld) begin
        out_data <= clip_dat;
        out_sat  <= clip_flag;
      end
    end
  end

  // Saturating event counter; a clear in the same cycle as an increment leaves zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_count <= '0;
    end else if (clr_count) begin
      sat_count <= '0;
    end else if (out_valid && out_ready && (|out_sat) && (sat_count != '1)) begin
      sat_count <= sat_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_round_sat_pipe.sv
// Bench for round_sat_pipe: signed default build, unsigned build and a 2-bit-counter build share one stimulus stream;
// directed test-plan vectors plus randomized traffic are scored against an arithmetic reference model.
module tb_round_sat_pipe;
  localparam int NCH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [127:0] in_data;
  logic [1:0]   in_mode;
  logic         out_ready;
  logic         clr_count;

  logic         in_ready, u_in_ready, c_in_ready;
  logic         out_valid, u_out_valid, c_out_valid;
  logic [63:0]  out_data, u_out_data, c_out_data;
  logic [3:0]   out_sat, u_out_sat, c_out_sat;
  logic [15:0]  sat_count, u_sat_count;
  logic [1:0]   c_sat_count;

  always #5 clk = ~clk;

  round_sat_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .sat_count(sat_count), .clr_count(clr_count));

  round_sat_pipe #(.IS_SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u_in_ready), .in_data(in_data),
    .in_mode(in_mode), .out_valid(u_out_valid), .out_ready(out_ready), .out_data(u_out_data),
    .out_sat(u_out_sat), .sat_count(u_sat_count), .clr_count(clr_count));

  round_sat_pipe #(.CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready), .in_data(in_data),
    .in_mode(in_mode), .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data),
    .out_sat(c_out_sat), .sat_count(c_sat_count), .clr_count(clr_count));

  typedef struct {
    logic [63:0] s_dat;
    logic [3:0]  s_sat;
    logic [63:0] u_dat;
    logic [3:0]  u_sat;
    int          acc_cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          last_stall = -1;
  int          n_xfer = 0;
  int          exp_cnt = 0, exp_ucnt = 0, exp_c2 = 0;
  logic        prev_stall = 1'b0;
  logic        acc_last = 1'b0;
  logic [63:0] last_s, last_u;
  logic [3:0]  last_ss, last_us;

  // Directed vectors on channel 0: din, mode, signed out/flag, unsigned out/flag.
  logic [31:0] t_din [15] = '{32'h0000_2800, 32'h0000_2800, 32'h0000_2800, 32'h0000_2800,
                              32'h0000_3800, 32'hFFFF_D800, 32'hFFFF_D800, 32'hFFFF_D800,
                              32'hFFFF_D800, 32'h07FF_F800, 32'h07FF_F800, 32'hF800_0000,
                              32'hF7FF_F000, 32'h0FFF_F800, 32'h0000_1800};
  logic [1:0]  t_mode[15] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd1, 2'd2,
                              2'd3, 2'd0, 2'd2, 2'd0, 2'd2, 2'd3, 2'd0};
  logic [15:0] t_s   [15] = '{16'h0002, 16'h0003, 16'h0002, 16'h0003, 16'h0004, 16'hFFFE,
                              16'hFFFD, 16'hFFFD, 16'hFFFE, 16'h7FFF, 16'h7FFF, 16'h8000,
                              16'h8000, 16'h7FFF, 16'h0002};
  logic        t_sf  [15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0};
  logic [15:0] t_u   [15] = '{16'h0002, 16'h0003, 16'h0002, 16'h0003, 16'h0004, 16'hFFFF,
                              16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h7FFF, 16'hFFFF,
                              16'hFFFF, 16'hFFFF, 16'h0002};
  logic        t_uf  [15] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1, 1, 0};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Real-valued rounding of d/4096 expressed with floor divisions.
  function automatic longint rnd(input longint d, input logic [1:0] m);
    longint v;
    case (m)
      2'd0: begin
        v = (d + 2048) >>> 12;
        if (((d & 4095) == 2048) && v[0]) v = v - 1;
      end
      2'd1:    v = (d < 0) ? -((2048 - d) >>> 12) : ((d + 2048) >>> 12);
      2'd2:    v = d >>> 12;
      default: v = (d + 2048) >>> 12;
    endcase
    return v;
  endfunction

  function automatic exp_t model(input logic [127:0] din, input logic [1:0] m);
    exp_t        e;
    longint      v;
    logic [31:0] x;
    e.s_dat = '0; e.s_sat = '0; e.u_dat = '0; e.u_sat = '0; e.acc_cyc = cyc;
    for (int c = 0; c < NCH; c++) begin
      x = din[c*32 +: 32];
      v = rnd(longint'($signed(x)), m);
      if (v > 32767)       begin e.s_dat[c*16 +: 16] = 16'h7FFF; e.s_sat[c] = 1'b1; end
      else if (v < -32768) begin e.s_dat[c*16 +: 16] = 16'h8000; e.s_sat[c] = 1'b1; end
      else                       e.s_dat[c*16 +: 16] = v[15:0];
      v = rnd(longint'(x), m);
      if (v > 65535)       begin e.u_dat[c*16 +: 16] = 16'hFFFF; e.u_sat[c] = 1'b1; end
      else                       e.u_dat[c*16 +: 16] = v[15:0];
    end
    return e;
  endfunction

  function automatic logic [31:0] rdin();
    int f;
    case ($urandom_range(0, 3))
      0: f = 2048;
      1: f = 2047;
      2: f = 2049;
      default: f = 0;
    endcase
    case ($urandom_range(0, 4))
      0:       return $urandom;
      1:       return 32'((int'($urandom_range(0, 64)) - 32) * 4096 + f);
      2:       return 32'h07FF_F000 + 32'($urandom_range(0, 8191)) - 32'd4096;
      3:       return 32'hF800_0000 + 32'($urandom_range(0, 8191)) - 32'd4096;
      default: return 32'h0FFF_F000 + 32'($urandom_range(0, 8191)) - 32'd4096;
    endcase
  endfunction

  function automatic logic [127:0] rbeat();
    return {rdin(), rdin(), rdin(), rdin()};
  endfunction

  // Inputs are driven 1 time unit after posedge; everything is observed at the following negedge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    check("sat_count", sat_count, exp_cnt);
    check("u_sat_count", u_sat_count, exp_ucnt);
    check("c2_sat_count", c_sat_count, exp_c2);
    check("in_ready", {in_ready, u_in_ready, c_in_ready}, {3{!out_valid || out_ready}});
    if (prev_stall) check("hold_valid", out_valid, 1'b1);
    if (out_valid) begin
      check("peer_valid", {u_out_valid, c_out_valid}, 2'b11);
      if (sb.size() == 0) begin
        check("spurious_beat", 1'b1, 1'b0);
      end else begin
        e = sb[0];
        check("out_data", out_data, e.s_dat);
        check("out_sat", out_sat, e.s_sat);
        check("u_out_data", u_out_data, e.u_dat);
        check("u_out_sat", u_out_sat, e.u_sat);
        check("c2_out_data", {c_out_sat, c_out_data}, {e.s_sat, e.s_dat});
        if (out_ready) begin
          if (last_stall < e.acc_cyc) check("latency", cyc - e.acc_cyc, 2);
          last_s = e.s_dat; last_ss = e.s_sat; last_u = e.u_dat; last_us = e.u_sat;
          void'(sb.pop_front());
          n_xfer++;
          if ((|e.s_sat) && exp_cnt < 65535) exp_cnt++;
          if ((|e.s_sat) && exp_c2 < 3) exp_c2++;
          if ((|e.u_sat) && exp_ucnt < 65535) exp_ucnt++;
        end
      end
    end
    if (clr_count) begin exp_cnt = 0; exp_ucnt = 0; exp_c2 = 0; end
    prev_stall = out_valid && !out_ready;
    if (prev_stall) last_stall = cyc;
    acc_last = in_valid && in_ready;
    if (acc_last) begin
      e = model(in_data, in_mode);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [127:0] d, input logic [1:0] m);
    in_data = d; in_mode = m; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, k, x0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 2'd0; out_ready = 1'b1; clr_count = 1'b0;
    #3;
    check("rst_out_valid", {out_valid, u_out_valid, c_out_valid}, 3'b000);
    check("rst_out_data", out_data, 64'h0);
    check("rst_out_sat", out_sat, 4'h0);
    check("rst_sat_count", sat_count, 16'h0);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // Directed rounding / clipping vectors.
    for (int i = 0; i < 15; i++) begin
      send_one({96'h0, t_din[i]}, t_mode[i]);
      check($sformatf("vec%0d_s", i), {last_ss[0], last_s[15:0]}, {t_sf[i], t_s[i]});
      check($sformatf("vec%0d_u", i), {last_us[0], last_u[15:0]}, {t_uf[i], t_u[i]});
      check($sformatf("vec%0d_hi", i), last_s[63:16], 48'h0);
    end

    // All channels at positive full scale.
    send_one({4{32'h7FFF_FFFF}}, 2'd1);
    check("allsat_data", last_s, 64'h7FFF_7FFF_7FFF_7FFF);
    check("allsat_flags", last_ss, 4'hF);

    // Streaming with a 3-cycle downstream stall.
    x0 = n_xfer; sent = 0; k = 0;
    in_valid = 1'b1; in_data = rbeat(); in_mode = 2'($urandom_range(0, 3));
    while ((sent < 8 || sb.size() > 0) && k < 100) begin
      out_ready = !(k >= 4 && k < 7);
      #1;
      if (k >= 4 && k < 7) check("stall_in_ready", in_ready, 1'b0);
      tick();
      k++;
      if (acc_last) begin
        sent++;
        if (sent < 8) begin in_data = rbeat(); in_mode = 2'($urandom_range(0, 3)); end
        else in_valid = 1'b0;
      end
    end
    out_ready = 1'b1;
    check("stream_beats", n_xfer - x0, 8);

    // Saturation counter: clear, 5 saturating beats, then a clear coinciding with a 6th.
    clr_count = 1'b1; tick(); clr_count = 1'b0;
    in_data = {4{32'h7FFF_FFFF}}; in_valid = 1'b1;
    repeat (5) tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("cnt_five", sat_count, 16'd5);
    check("cnt_w2_sticks", c_sat_count, 2'd3);
    check("u_cnt_five", u_sat_count, 16'd5);
    in_valid = 1'b1; tick(); in_valid = 1'b0; tick();
    clr_count = 1'b1; tick(); clr_count = 1'b0; tick();
    check("cnt_clear_wins", sat_count, 16'd0);

    // Reset with two beats in flight.
    in_valid = 1'b1; in_data = rbeat(); tick();
    in_data = rbeat(); tick();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_data", out_data, 64'h0);
    check("midrst_sat_count", sat_count, 16'h0);
    sb.delete(); exp_cnt = 0; exp_ucnt = 0; exp_c2 = 0; prev_stall = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) tick();
    in_valid = 1'b1; in_data = rbeat(); in_mode = 2'd0;
    tick();
    in_valid = 1'b0;
    check("postrst_lat1", out_valid, 1'b0);
    tick();
    check("postrst_lat2", out_valid, 1'b1);
    tick();

    // Randomized traffic with random backpressure and clears.
    acc_last = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!in_valid || acc_last) begin
        in_valid = ($urandom_range(0, 9) < 7);
        in_data  = rbeat();
        in_mode  = 2'($urandom_range(0, 3));
      end
      out_ready = ($urandom_range(0, 9) < 7);
      clr_count = ($urandom_range(0, 49) == 0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1; clr_count = 1'b0;
    repeat (4) tick();
    check("final_drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/round_sat_pipe.md
Name: round_sat_pipe

Overview:
Multi-channel, pipelined rounding/saturation stage. Each channel narrows a WIDTH_IN sample to WIDTH_OUT by dropping SHIFT fractional LSBs under a run-time rounding mode, then clips to the output range. It is the generalised successor of the single-channel unbiased rounder. It sits between wide DSP accumulators and narrow datapaths, uses a valid/ready stream interface, and keeps a saturation-event counter.

Parameters:
WIDTH_IN, 32, input sample width per channel.
WIDTH_OUT, 16, output sample width per channel.
SHIFT, 12, LSBs discarded; legal range 1 <= SHIFT <= WIDTH_IN-WIDTH_OUT.
NUM_CH, 4, channels processed in lockstep.
IS_SIGNED, 1, 1 = two's-complement in/out; 0 = unsigned.
CNT_W, 16, saturation event counter width.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  input beat valid.
in_ready  out  1  block accepts a beat this cycle.
in_data  in  NUM_CH*WIDTH_IN  channel c at bits [c*WIDTH_IN +: WIDTH_IN].
in_mode  in  2  rounding mode, sampled with the beat: 0 half-even, 1 half-away-from-zero, 2 truncate (floor), 3 half-up (toward +inf).
out_valid  out  1  output beat valid.
out_ready  in  1  downstream accepts the beat.
out_data  out  NUM_CH*WIDTH_OUT  rounded, clipped samples; same channel packing as in_data.
out_sat  out  NUM_CH  per-channel flag: this output sample was clipped.
sat_count  out  CNT_W  number of transferred output beats with any out_sat bit set.
clr_count  in  1  synchronous clear of sat_count.

Behaviour:
- Reset, asynchronous: out_valid=0, out_data=0, out_sat=0, sat_count=0, internal stage-1 valid=0. Reset asserted mid-stream discards all in-flight beats. in_ready is combinational and reads 1 after reset.
- Two-stage pipeline:
  - S1 registers per-channel Q+inc with one guard bit and registers the mode-independent sign.
  - S2 saturates and drives the outputs.
- Global stall: advance = !out_valid | out_ready; in_ready = advance. Both stages load only when advance=1.
- Latency: 2 cycles from accepted beat to out_valid with no backpressure. Throughput is 1 beat/cycle. Bubbles propagate as valid=0.
- While out_valid=1 and out_ready=0, out_data, out_sat and out_valid stay stable.
- Per-channel arithmetic:
  - Q = din >> SHIFT (arithmetic shift if IS_SIGNED, otherwise logical). Q is the floor.
  - R = din[SHIFT-1:0]; H = 1<<(SHIFT-1).
  - inc by mode:
    - mode 0: R>H, or (R==H and Q[0]==1).
    - mode 1: R>H, or (R==H and din non-negative).
    - mode 2: 0.
    - mode 3: R>=H.
  - V = Q + inc, computed in WIDTH_IN-SHIFT+1 bits (never wraps).
- Clip:
  - Signed: V > 2^(WIDTH_OUT-1)-1 → max and flag; V < -2^(WIDTH_OUT-1) → min and flag.
  - Unsigned: V > 2^WIDTH_OUT-1 → max and flag.
  - Otherwise out = V[WIDTH_OUT-1:0] and flag=0.
- Modes apply independently per beat; consecutive beats may use different modes.
- sat_count: increments by 1 on each cycle with out_valid & out_ready & |out_sat. It holds at all-ones and does not wrap. If clr_count is asserted in the same cycle as an increment, clear wins and the result is 0.
- All channels are independent; one channel's saturation does not affect the others.

Test Plan:
Values below use defaults (W 32→16, SHIFT 12, H=0x800), signed, ch0 shown, other channels 0.
- Ties: din 0x00002800 (2.5) → mode0 2, mode1 3, mode2 2, mode3 3. din 0x00003800 (3.5) mode0 → 4. din -0x2800 → mode0 -2, mode1 -3, mode2 -3, mode3 -2. out_sat=0 in all cases.
- Saturation edges:
  - din 0x07FFF800 (32767.5), mode0 → Q odd, V=32768 → out 0x7FFF, out_sat[0]=1.
  - Same din, mode2 → 0x7FFF, flag 0.
  - din 0xF8000000 → 0x8000, flag 0.
  - din 0xF7FFF000 → 0x8000, flag 1.
  - din 0x7FFFFFFF on all channels → all 0x7FFF, out_sat=4'hF.
- Handshake: stream 8 beats with in_valid held high and out_ready=1 → outputs in order, 2-cycle latency. Then drop out_ready for 3 cycles mid-stream → in_ready=0, outputs stable, no loss or duplication, order preserved.
- Counter: 5 saturating beats transferred → sat_count=5. Assert clr_count together with a 6th saturating beat → sat_count=0. Preload a CNT_W=2 build with 4 saturating beats → count sticks at 3.
- Reset mid-operation: assert rst with 2 beats in flight → out_valid=0 and out_data=0 immediately (asynchronous). After release, no stale beat appears; next input emerges 2 cycles after acceptance.
- Unsigned build (IS_SIGNED=0): din 0x0FFFF800 mode3 → V=65536 → 0xFFFF, flag 1. din 0x00001800 mode0 → 2.
